// File: rtl/alu_8bit.sv
// alu_8bit: registered 8-bit ALU with eight operations and optional status flags.
// The flag logic and flag registers exist only when ALU_STATUS_FLAGS_EN is defined.
// Without it, c8_o/v8_o/z8_o/n8_o are tied to 0 and y8_o behaves the same.
// Reset is synchronous and active-high, and it clears every output register.
module alu_8bit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] a8_i,
  input  logic [DATA_WIDTH-1:0] b8_i,
  input  logic [3:0]            f8_i,
  output logic [DATA_WIDTH-1:0] y8_o,
  output logic                  c8_o,
  output logic                  v8_o,
  output logic                  z8_o,
  output logic                  n8_o
);

  localparam logic [3:0] ALL_ZERO         = 4'b0000;
  localparam logic [3:0] OUTPUT_A         = 4'b0001;
  localparam logic [3:0] OUTPUT_NOT_A     = 4'b0010;
  localparam logic [3:0] OUTPUT_A_AND_B   = 4'b0011;
  localparam logic [3:0] OUTPUT_A_OR_B    = 4'b0100;
  localparam logic [3:0] OUTPUT_A_XOR_B   = 4'b0101;
  localparam logic [3:0] OUTPUT_A_PLUS_B  = 4'b0110;
  localparam logic [3:0] OUTPUT_B_MINUS_A = 4'b0111;

  logic [DATA_WIDTH-1:0] addY;
  logic [DATA_WIDTH-1:0] subY;
  logic [DATA_WIDTH-1:0] y_d;
  logic [DATA_WIDTH-1:0] y_q;

`ifdef ALU_STATUS_FLAGS_EN
  // The adders are 9 bits wide so the carry-out is available for the C flag
  logic [DATA_WIDTH:0] addSum;
  logic [DATA_WIDTH:0] subSum;
  logic c_d, v_d, z_d, n_d;
  logic c_q, v_q, z_q, n_q;

  assign addSum = {1'b0, a8_i} + {1'b0, b8_i};
  assign subSum = {1'b0, b8_i} + {1'b0, ~a8_i} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign addY   = addSum[DATA_WIDTH-1:0];
  assign subY   = subSum[DATA_WIDTH-1:0];
`else
  // In the flagless build the carry-out is not needed, so the adders stay at the data width
  assign addY = a8_i + b8_i;
  assign subY = b8_i + ~a8_i + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
`endif

  // Select the result for the current opcode; reserved codes give zero
  always_comb begin
    y_d = '0;
    case (f8_i)
      ALL_ZERO:         y_d = '0;
      OUTPUT_A:         y_d = a8_i;
      OUTPUT_NOT_A:     y_d = ~a8_i;
      OUTPUT_A_AND_B:   y_d = a8_i & b8_i;
      OUTPUT_A_OR_B:    y_d = a8_i | b8_i;
      OUTPUT_A_XOR_B:   y_d = a8_i ^ b8_i;
      OUTPUT_A_PLUS_B:  y_d = addY;
      OUTPUT_B_MINUS_A: y_d = subY;
      default:          y_d = '0;
    endcase
  end

  // Capture the result on every edge; reset overrides the opcode
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y8_o = y_q;

`ifdef ALU_STATUS_FLAGS_EN
  // Derive the flags. Carry and overflow come only from add/subtract.
  // Reserved codes force every flag to 0, even though Y is 0 for them.
  always_comb begin
    c_d = 1'b0;
    v_d = 1'b0;
    z_d = 1'b0;
    n_d = 1'b0;
    if (!f8_i[3]) begin
      z_d = (y_d == '0);
      n_d = y_d[DATA_WIDTH-1];
      if (f8_i == OUTPUT_A_PLUS_B) begin
        c_d = addSum[DATA_WIDTH];
        v_d = (a8_i[DATA_WIDTH-1] == b8_i[DATA_WIDTH-1]) &&
              (addSum[DATA_WIDTH-1] != a8_i[DATA_WIDTH-1]);
      end else if (f8_i == OUTPUT_B_MINUS_A) begin
        c_d = subSum[DATA_WIDTH];
        v_d = (b8_i[DATA_WIDTH-1] == ~a8_i[DATA_WIDTH-1]) &&
              (subSum[DATA_WIDTH-1] != b8_i[DATA_WIDTH-1]);
      end
    end
  end

  // Capture the flags alongside the result; reset clears them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      c_q <= c_d;
      v_q <= v_d;
      z_q <= z_d;
      n_q <= n_d;
    end
  end

  assign c8_o = c_q;
  assign v8_o = v_q;
  assign z8_o = z_q;
  assign n8_o = n_q;
`else
  assign c8_o = 1'b0;
  assign v8_o = 1'b0;
  assign z8_o = 1'b0;
  assign n8_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: self-checking bench for alu_8bit.
// It runs the directed cases first and then randomised operations.
// The reference model below works on plain integer arithmetic.
module tb_alu_8bit;

`ifdef ALU_STATUS_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] aIn;
  logic [7:0] bIn;
  logic [3:0] fIn;
  logic [7:0] yOut;
  logic       cOut, vOut, zOut, nOut;

  int totalCount = 0;
  int badCount   = 0;

  alu_8bit #(.DATA_WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .a8_i  (aIn),
    .b8_i  (bIn),
    .f8_i  (fIn),
    .y8_o  (yOut),
    .c8_o  (cOut),
    .v8_o  (vOut),
    .z8_o  (zOut),
    .n8_o  (nOut)
  );

  // Free-running clock with a 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {Y, C, V, Z, N} for one operation, worked out with integer arithmetic
  function automatic logic [11:0] refModel(input int a, input int b, input int f);
    int y, c, v, r;
    y = 0; c = 0; v = 0;
    case (f)
      0: y = 0;
      1: y = a;
      2: y = 255 - a;
      3: y = a & b;
      4: y = a | b;
      5: y = a ^ b;
      6: begin
        y = (a + b) % 256;
        c = (a + b > 255) ? 1 : 0;
        r = (a > 127 ? a - 256 : a) + (b > 127 ? b - 256 : b);
        v = (r > 127 || r < -128) ? 1 : 0;
      end
      7: begin
        y = (b - a + 256) % 256;
        c = (b >= a) ? 1 : 0;
        r = (b > 127 ? b - 256 : b) - (a > 127 ? a - 256 : a);
        v = (r > 127 || r < -128) ? 1 : 0;
      end
      default: y = 0;
    endcase
    if (f > 7 || !FLAGS) begin
      return {y[7:0], 4'b0000};
    end
    return {y[7:0], c[0], v[0], (y == 0), (y >= 128)};
  endfunction

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the operands on the falling edge, then wait until just after the next rising edge
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f, input logic r);
    @(negedge clk);
    aIn = a; bIn = b; fIn = f; rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] observedPack();
    return {yOut, cOut, vOut, zOut, nOut};
  endfunction

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
    logic [7:0] expY;
  } vecT;

  vecT vecs[$];

  initial begin
    aIn = 8'h00; bIn = 8'h00; fIn = 4'h0; rst = 1'b1;

    // Reset wins over the opcode
    applyStimulus(8'hFF, 8'hFF, 4'd6, 1'b1);
    checkOutput("reset", observedPack(), 12'h000);
    applyStimulus(8'hFF, 8'hFF, 4'd6, 1'b0);
    checkOutput("post_reset_y", {4'h0, yOut}, 12'h0FE);
    checkOutput("post_reset_c", {11'h0, cOut}, {11'h0, FLAGS});
    checkOutput("post_reset_all", observedPack(), refModel(255, 255, 6));

    vecs.push_back('{"not_a",   8'hAA, 8'h00, 4'd2, 8'h55});
    vecs.push_back('{"and",     8'hFF, 8'h91, 4'd3, 8'h91});
    vecs.push_back('{"or",      8'hF0, 8'h0F, 4'd4, 8'hFF});
    vecs.push_back('{"xor",     8'h42, 8'h91, 4'd5, 8'hD3});
    vecs.push_back('{"zero",    8'h5A, 8'hA5, 4'd0, 8'h00});
    vecs.push_back('{"add33",   8'd33, 8'd66, 4'd6, 8'd99});
    vecs.push_back('{"add255",  8'd255, 8'd1, 4'd6, 8'h00});
    vecs.push_back('{"add200",  8'd200, 8'd150, 4'd6, 8'h5E});
    vecs.push_back('{"add7f",   8'h7F, 8'h01, 4'd6, 8'h80});
    vecs.push_back('{"sub10_5", 8'd5, 8'd10, 4'd7, 8'd5});
    vecs.push_back('{"sub5_10", 8'd10, 8'd5, 4'd7, 8'hFB});
    vecs.push_back('{"sub0_1",  8'd1, 8'd0, 4'd7, 8'hFF});
    vecs.push_back('{"sub50",   8'd255, 8'd50, 4'd7, 8'h33});
    vecs.push_back('{"sub255",  8'd255, 8'd255, 4'd7, 8'h00});
    vecs.push_back('{"b2b_a",   8'd100, 8'd0, 4'd1, 8'd100});
    vecs.push_back('{"b2b_rsv", 8'd100, 8'd3, 4'b1010, 8'h00});
    vecs.push_back('{"b2b_add", 8'd50, 8'd50, 4'd6, 8'd100});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].f, 1'b0);
      checkOutput({vecs[i].tag, "_y"}, {4'h0, yOut}, {4'h0, vecs[i].expY});
      checkOutput({vecs[i].tag, "_all"}, observedPack(), refModel(vecs[i].a, vecs[i].b, vecs[i].f));
    end

    // Spot-check the named flags from the directed cases with literal values
    applyStimulus(8'd255, 8'd1, 4'd6, 1'b0);
    checkOutput("add255_flags", {8'h0, cOut, vOut, zOut, nOut}, {8'h0, FLAGS, 1'b0, FLAGS, 1'b0});
    applyStimulus(8'h7F, 8'h01, 4'd6, 1'b0);
    checkOutput("add7f_flags", {8'h0, cOut, vOut, zOut, nOut}, {8'h0, 1'b0, FLAGS, 1'b0, FLAGS});
    applyStimulus(8'd10, 8'd5, 4'd7, 1'b0);
    checkOutput("sub5_10_flags", {8'h0, cOut, vOut, zOut, nOut}, {8'h0, 1'b0, 1'b0, 1'b0, FLAGS});
    applyStimulus(8'd0, 8'd0, 4'd0, 1'b0);
    checkOutput("zero_flags", {8'h0, cOut, vOut, zOut, nOut}, {8'h0, 1'b0, 1'b0, FLAGS, 1'b0});
    applyStimulus(8'd0, 8'd0, 4'b1111, 1'b0);
    checkOutput("reserved_flags", observedPack(), 12'h000);

    // Inputs that change between edges must not reach the outputs
    applyStimulus(8'h12, 8'h34, 4'd4, 1'b0);
    aIn = 8'hFF; bIn = 8'hFF; fIn = 4'd2;
    @(negedge clk);
    checkOutput("hold_between_edges", observedPack(), refModel(8'h12, 8'h34, 4'd4));

    // A reset in mid-stream drops the in-flight result; the next edge brings a valid result again
    applyStimulus(8'h80, 8'h80, 4'd6, 1'b1);
    checkOutput("midstream_reset", observedPack(), 12'h000);
    applyStimulus(8'h80, 8'h80, 4'd6, 1'b0);
    checkOutput("after_midstream_reset", observedPack(), refModel(8'h80, 8'h80, 6));

    // Randomised operations over all sixteen opcodes
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra, rb;
      logic [3:0] rf;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rf = 4'($urandom_range(0, 15));
      applyStimulus(ra, rb, rf, 1'b0);
      checkOutput($sformatf("rand%0d_f%0d", i, rf), observedPack(), refModel(ra, rb, rf));
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
